// File: rtl/line_xfer_engine.sv
// line_xfer_engine: moves one 4-word cache line between the data array and memory.
// An optional victim writeback comes first, then the line fill. Read data comes
// back 2 cycles after the memory accepts the request, and each word is written
// into the cache as it returns.
// Optional feature: define LXE_CRITICAL_WORD_FIRST_EN to start the fill at the
// requested word and wrap around from there.
module line_xfer_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic        cmd_wb,
    output logic        cmd_ready,
    input  logic [12:0] fill_addr,
    input  logic [1:0]  fill_word,
    input  logic [12:0] wb_addr,
    output logic [1:0]  cache_word_sel,
    input  logic [15:0] cache_rd_word,
    output logic        cache_wr,
    output logic [15:0] cache_wr_data,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_data_out,
    input  logic [15:0] mem_data_in,
    input  logic        mem_stall,
    input  logic        mem_err,
    output logic        done,
    output logic        err,
    output logic        crit_word_valid
);
    localparam int unsigned LINE_AW = 13;
    localparam int unsigned WORD_W  = 16;
    localparam int unsigned IDX_W   = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WB,
        ST_RD,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [LINE_AW-1:0] fill_addr_q, fill_addr_d;
    logic [LINE_AW-1:0] wb_addr_q, wb_addr_d;
    logic               err_q, err_d;
    logic               p1_v_q, p1_v_d;
    logic [IDX_W-1:0]   p1_idx_q, p1_idx_d;
    logic               p2_v_q;
    logic [IDX_W-1:0]   p2_idx_q;
    logic [IDX_W-1:0]   rd_idx;
    logic               accept;

    assign accept = cmd_valid && (state_q == ST_IDLE);

`ifdef LXE_CRITICAL_WORD_FIRST_EN
    logic [IDX_W-1:0] start_q;

    // The first fill word is the requested word; the counter adds the wrap offset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            start_q <= '0;
        end else if (accept) begin
            start_q <= fill_word;
        end
    end

    assign rd_idx          = start_q + cnt_q;
    assign crit_word_valid = p2_v_q && (p2_idx_q == start_q);
`else
    logic unused_fill_word;

    assign unused_fill_word = ^fill_word;
    assign rd_idx           = cnt_q;
    assign crit_word_valid  = 1'b0;
`endif

    // State, counter, latched command and read-tracking pipeline
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            err_q       <= 1'b0;
            p1_v_q      <= 1'b0;
            p1_idx_q    <= '0;
            p2_v_q      <= 1'b0;
            p2_idx_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
            wb_addr_q   <= wb_addr_d;
            err_q       <= err_d;
            p1_v_q      <= p1_v_d;
            p1_idx_q    <= p1_idx_d;
            p2_v_q      <= p1_v_q;
            p2_idx_q    <= p1_idx_q;
        end
    end

    // Next-state logic; an error stops issuing and drains whatever reads are in flight
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fill_addr_d = fill_addr_q;
        wb_addr_d   = wb_addr_q;
        err_d       = err_q;
        p1_v_d      = 1'b0;
        p1_idx_d    = rd_idx;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    fill_addr_d = fill_addr;
                    wb_addr_d   = wb_addr;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = cmd_wb ? ST_WB : ST_RD;
                end
            end
            ST_WB: begin
                if (mem_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (!mem_stall) begin
                    cnt_d = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(3)) begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_err) begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end else if (!mem_stall) begin
                    p1_v_d = 1'b1;
                    cnt_d  = cnt_q + IDX_W'(1);
                    if (cnt_q == IDX_W'(3)) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (!p1_v_q && !p2_v_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decode registered state; data buses pass through only while in use
    assign cmd_ready      = (state_q == ST_IDLE);
    assign mem_wr         = (state_q == ST_WB);
    assign mem_rd         = (state_q == ST_RD);
    assign mem_addr       = mem_wr ? {wb_addr_q, cnt_q, 1'b0} :
                            mem_rd ? {fill_addr_q, rd_idx, 1'b0} : '0;
    assign mem_data_out   = mem_wr ? cache_rd_word : WORD_W'(0);
    assign cache_wr       = p2_v_q;
    assign cache_wr_data  = p2_v_q ? mem_data_in : WORD_W'(0);
    assign cache_word_sel = mem_wr ? cnt_q : (p2_v_q ? p2_idx_q : '0);
    assign done           = (state_q == ST_DONE);
    assign err            = (state_q == ST_DONE) && err_q;

endmodule
